// File: rtl/fft_r22sdf_bitrev.sv
// fft_r22sdf_bitrev
// Output reorder buffer for the R22SDF FFT. Frames arrive in bit-reversed
// bin order and leave in natural order 0..N-1. Two N-entry banks live in one
// 1W/1R RAM (bank = address MSB) so a continuous input stream produces a
// continuous output stream.
//
// Ports:
//   clk_i            clock
//   rst_n            synchronous active-low reset
//   valid_i          x_re_i/x_im_i carry a sample (bit-reversed order)
//   x_re_i, x_im_i   complex input sample, DATA_WIDTH each
//   valid_o          z_re_o/z_im_o/bin_o carry an output sample
//   z_re_o, z_im_o   complex output sample, natural order
//   bin_o            natural bin index of the current output
//   sof_o            high together with bin 0 of each output frame
module fft_r22sdf_bitrev #(
  parameter int DATA_WIDTH = 25,
  parameter int N_LOG2     = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] x_re_i,
  input  logic [DATA_WIDTH-1:0] x_im_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] z_re_o,
  output logic [DATA_WIDTH-1:0] z_im_o,
  output logic [N_LOG2-1:0]     bin_o,
  output logic                  sof_o
);

  localparam int WORD_W = 2 * DATA_WIDTH;
  localparam int DEPTH  = 2 ** (N_LOG2 + 1);
  localparam logic [N_LOG2-1:0] CNT_ZERO = {N_LOG2{1'b0}};
  localparam logic [N_LOG2-1:0] CNT_ONE  = N_LOG2'(1);
  localparam logic [N_LOG2-1:0] CNT_LAST = {N_LOG2{1'b1}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  // Reverse the order of all N_LOG2 bits of a counter value.
  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = v[N_LOG2-1-i];
    end
    return r;
  endfunction

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] ram_q_r;

  logic [N_LOG2-1:0] wcnt_r;
  logic [N_LOG2-1:0] rcnt_r;
  logic              wbank_r;
  logic              rbank_r;
  logic [1:0]        full_r;
  logic [1:0]        full_nx_s;
  state_t            state_r;
  state_t            state_nx_s;

  logic              wr_wrap_s;
  logic              rd_en_s;
  logic              rd_last_s;
  logic              rd_vld_r;
  logic [N_LOG2-1:0] rd_bin_r;

  assign wr_wrap_s = valid_i && (wcnt_r == CNT_LAST);

  // Read FSM next state: a read is issued every cycle the current read bank is full.
  always_comb begin
    state_nx_s = state_r;
    rd_en_s    = 1'b0;
    rd_last_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (full_r[rbank_r]) begin
          rd_en_s    = 1'b1;
          state_nx_s = ST_READ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (full_r[rbank_r]) begin
          rd_en_s    = 1'b1;
          state_nx_s = ST_READ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    // Last address of the bank: continue straight into the other bank when it
    // is already full or is being completed by the writer this very cycle.
    if (rd_en_s && (rcnt_r == CNT_LAST)) begin
      rd_last_s  = 1'b1;
      state_nx_s = (full_r[~rbank_r] || (wr_wrap_s && (wbank_r != rbank_r))) ? ST_READ : ST_IDLE;
    end else begin
      rd_last_s  = 1'b0;
    end
  end

  // Full flags: the writer sets its bank on wrap, the reader clears its bank on finish.
  always_comb begin
    full_nx_s[0] = (wr_wrap_s && !wbank_r) || (full_r[0] && !(rd_last_s && !rbank_r));
    full_nx_s[1] = (wr_wrap_s &&  wbank_r) || (full_r[1] && !(rd_last_s &&  rbank_r));
  end

  // Control state: counters, bank pointers, full flags, FSM state.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wcnt_r  <= CNT_ZERO;
      rcnt_r  <= CNT_ZERO;
      wbank_r <= 1'b0;
      rbank_r <= 1'b0;
      full_r  <= 2'b00;
      state_r <= ST_IDLE;
    end else begin
      full_r  <= full_nx_s;
      state_r <= state_nx_s;
      if (valid_i) begin
        wcnt_r <= wcnt_r + CNT_ONE;
        if (wr_wrap_s) begin
          wbank_r <= ~wbank_r;
        end
      end
      if (rd_en_s) begin
        rcnt_r <= rcnt_r + CNT_ONE;
        if (rd_last_s) begin
          rbank_r <= ~rbank_r;
        end
      end
    end
  end

  // RAM write port: incoming sample lands at its natural-order address.
  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      mem_r[{wbank_r, bitrev(wcnt_r)}] <= {x_re_i, x_im_i};
    end
  end

  // RAM read port, one cycle latency; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (rd_en_s) begin
      ram_q_r <= mem_r[{rbank_r, rcnt_r}];
    end
  end

  // Read pipeline and registered outputs; data/bin hold while valid_o is low.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      rd_vld_r <= 1'b0;
      rd_bin_r <= CNT_ZERO;
      valid_o  <= 1'b0;
      sof_o    <= 1'b0;
      z_re_o   <= {DATA_WIDTH{1'b0}};
      z_im_o   <= {DATA_WIDTH{1'b0}};
      bin_o    <= CNT_ZERO;
    end else begin
      rd_vld_r <= rd_en_s;
      rd_bin_r <= rcnt_r;
      valid_o  <= rd_vld_r;
      if (rd_vld_r) begin
        z_re_o <= ram_q_r[WORD_W-1:DATA_WIDTH];
        z_im_o <= ram_q_r[DATA_WIDTH-1:0];
        bin_o  <= rd_bin_r;
        sof_o  <= (rd_bin_r == CNT_ZERO);
      end else begin
        sof_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_r22sdf_bitrev.sv
// Self-checking bench for fft_r22sdf_bitrev: an N=8 instance for the
// directed tests and an N=1024 instance for the random full-size frame.
// A frame-level reference model predicts every output cycle of both.
module tb_fft_r22sdf_bitrev;

  typedef struct {
    int due;
    logic signed [24:0] re;
    logic signed [24:0] im;
    int bin;
  } exp_t;

  typedef struct {
    int x_re;
    int x_im;
    int exp_re;
    int exp_im;
    int exp_bin;
  } vec_t;

  logic clk_i;
  logic rst_n;
  logic vi [2];
  logic signed [24:0] re_d [2];
  logic signed [24:0] im_d [2];
  logic v_o [2];
  logic s_o [2];
  logic signed [24:0] zr [2];
  logic signed [24:0] zi [2];
  logic [9:0] bn [2];

  int total;
  int bad;
  int ecnt;
  bit mon_en;

  logic signed [24:0] fre [2][$];
  logic signed [24:0] fim [2][$];
  exp_t exq [2][$];
  exp_t ent;
  logic signed [24:0] lre [2];
  logic signed [24:0] lim [2];
  logic [9:0] lbin [2];

  vec_t tv [8];
  int exp4 [8];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int LG = (g == 0) ? 3 : 10;
    logic [LG-1:0] bin_s;
    assign bn[g] = 10'(bin_s);
    fft_r22sdf_bitrev #(.DATA_WIDTH(25), .N_LOG2(LG)) u_dut (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .valid_i (vi[g]),
      .x_re_i  (re_d[g]),
      .x_im_i  (im_d[g]),
      .valid_o (v_o[g]),
      .z_re_o  (zr[g]),
      .z_im_o  (zi[g]),
      .bin_o   (bin_s),
      .sof_o   (s_o[g])
    );
  end

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int rev(input int v, input int bits);
    int r = 0;
    int x = v;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [63:0] pack(input logic v, input logic s, input logic [24:0] re,
                                       input logic [24:0] im, input logic [9:0] bin);
    return {2'b00, v, s, re, im, bin};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total = total + 1;
    if (act !== expv) begin
      bad = bad + 1;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, ecnt, act, expv);
    end
  endtask

  // Reference model: collect whole frames, emit them in natural order two
  // cycles after the last sample; check every output cycle on the falling edge.
  always begin
    @(posedge clk_i);
    ecnt = ecnt + 1;
    for (int g = 0; g < 2; g++) begin
      int n;
      n = (g == 0) ? 8 : 1024;
      if (!rst_n) begin
        fre[g].delete();
        fim[g].delete();
        exq[g].delete();
        lre[g] = 25'sd0;
        lim[g] = 25'sd0;
        lbin[g] = 10'd0;
      end else if (vi[g]) begin
        fre[g].push_back(re_d[g]);
        fim[g].push_back(im_d[g]);
        if (fre[g].size() == n) begin
          for (int k = 0; k < n; k++) begin
            int j;
            j = rev(k, (g == 0) ? 3 : 10);
            ent.due = ecnt + 2 + k;
            ent.re = fre[g][j];
            ent.im = fim[g][j];
            ent.bin = k;
            exq[g].push_back(ent);
          end
          fre[g].delete();
          fim[g].delete();
        end
      end
    end
    @(negedge clk_i);
    if (mon_en) begin
      for (int g = 0; g < 2; g++) begin
        if (exq[g].size() != 0 && exq[g][0].due == ecnt) begin
          ent = exq[g].pop_front();
          chk((g == 0) ? "model_out_n8" : "model_out_n1024",
              pack(v_o[g], s_o[g], zr[g], zi[g], bn[g]),
              pack(1'b1, ent.bin == 0, ent.re, ent.im, 10'(ent.bin)));
          lre[g] = ent.re;
          lim[g] = ent.im;
          lbin[g] = 10'(ent.bin);
        end else begin
          chk((g == 0) ? "model_idle_n8" : "model_idle_n1024",
              pack(v_o[g], s_o[g], zr[g], zi[g], bn[g]),
              pack(1'b0, 1'b0, lre[g], lim[g], lbin[g]));
        end
      end
    end
  end

  task automatic push(input int g, input bit v, input int r, input int i);
    vi[g] = v;
    re_d[g] = 25'(r);
    im_d[g] = 25'(i);
    @(posedge clk_i);
    #1;
    vi[g] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    tv[0] = '{0,  0, 0,  0, 0};
    tv[1] = '{1, -1, 4, -4, 1};
    tv[2] = '{2, -2, 2, -2, 2};
    tv[3] = '{3, -3, 6, -6, 3};
    tv[4] = '{4, -4, 1, -1, 4};
    tv[5] = '{5, -5, 5, -5, 5};
    tv[6] = '{6, -6, 3, -3, 6};
    tv[7] = '{7, -7, 7, -7, 7};
    exp4 = '{10, 14, 12, 16, 11, 15, 13, 17};

    total = 0;
    bad = 0;
    ecnt = 0;
    mon_en = 1'b0;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      vi[g] = 1'b0;
      re_d[g] = 25'sd0;
      im_d[g] = 25'sd0;
    end
    idle(3);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk_i);
    chk("reset_state", pack(v_o[0], s_o[0], zr[0], zi[0], bn[0]), 64'd0);
    idle(2);

    // Test 1: single frame, exact latency, table-driven
    for (int i = 0; i < 8; i++) push(0, 1'b1, tv[i].x_re, tv[i].x_im);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("t1_not_early", {63'd0, v_o[0]}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("t1_out", pack(v_o[0], s_o[0], zr[0], zi[0], bn[0]),
          pack(1'b1, k == 0, 25'(tv[k].exp_re), 25'(tv[k].exp_im), 10'(tv[k].exp_bin)));
    end
    idle(4);

    // Test 2: three back-to-back frames
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 8; i++) push(0, 1'b1, 8 * f + i, -(8 * f + i));
    idle(12);

    // Test 3: valid_i toggling across a frame
    for (int i = 0; i < 8; i++) begin
      push(0, 1'b1, i, -i);
      if (i < 7) push(0, 1'b0, 0, 0);
    end
    idle(12);

    // Test 4: reset after a partial frame, then a full frame
    for (int i = 0; i < 5; i++) push(0, 1'b1, 100 + i, -(100 + i));
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push(0, 1'b1, 10 + i, -(10 + i));
    @(posedge clk_i);
    @(negedge clk_i);
    chk("t4_not_early", {63'd0, v_o[0]}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("t4_out", pack(v_o[0], s_o[0], zr[0], zi[0], bn[0]),
          pack(1'b1, k == 0, 25'(exp4[k]), 25'(-exp4[k]), 10'(k)));
    end
    idle(4);

    // Test 5: reset in the middle of an output frame
    for (int i = 0; i < 8; i++) push(0, 1'b1, 20 + i, -(20 + i));
    repeat (4) @(posedge clk_i);
    #1;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("t5_reset_out", pack(v_o[0], s_o[0], zr[0], zi[0], bn[0]), 64'd0);
    for (int i = 0; i < 8; i++) push(0, 1'b1, 30 + i, -(30 + i));
    idle(12);

    // Test 6: N=1024 random frame with extremes
    for (int i = 0; i < 1024; i++) begin
      int r;
      int m;
      r = int'($urandom_range(0, 33554431));
      m = int'($urandom_range(0, 33554431));
      if (i == 3)   r = 16777215;
      if (i == 700) r = -16777215;
      if (i == 11)  m = -16777215;
      if (i == 512) m = 16777215;
      push(1, 1'b1, r, m);
    end
    idle(1034);

    chk("drain_n8", 64'(exq[0].size()), 64'd0);
    chk("drain_n1024", 64'(exq[1].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
